// File: rtl/fmul_round_pack.sv
// Packs FMUL final-stage fields into an IEEE-754 single word and queues them
// in a small in-order output FIFO, with sticky status flags and saturating event counters.
module fmul_round_pack #(
   parameter int FIFO_DEPTH = 2,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             RESET,
   input  logic             in_valid,
   input  logic             in_sign,
   input  logic [7:0]       in_exp,
   input  logic [23:0]      in_frac,
   input  logic             in_error,
   input  logic             in_overflow,
   output logic             in_ready,
   output logic             out_valid,
   output logic [31:0]      out_data,
   input  logic             out_ready,
   input  logic             clr_flags,
   output logic             flag_invalid,
   output logic             flag_overflow,
   output logic             flag_underflow,
   output logic             flag_drop,
   output logic [CNT_W-1:0] cnt_invalid,
   output logic [CNT_W-1:0] cnt_overflow
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [PTR_W:0] FULL_CNT = FIFO_DEPTH[PTR_W:0];

   function automatic logic [31:0] pack_word(input logic sign, input logic [7:0] exp,
                                             input logic [23:0] frac, input logic err,
                                             input logic ovf);
      logic [31:0] w;
      if (err)
         w = 32'h7FC0_0000;
      else if (ovf || exp == 8'hFF)
         w = {sign, 8'hFF, 23'd0};
      else if (exp == 8'd0 || frac == 24'd0 || (exp == 8'd1 && !frac[23]))
         w = {sign, 31'd0};
      else if (frac[23])
         w = {sign, exp, frac[22:0]};
      else
         w = {sign, exp - 8'd1, frac[21:0], 1'b0};
      return w;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic ev);
      logic [CNT_W-1:0] r;
      r = c;
      if (ev && c != {CNT_W{1'b1}})
         r = c + 1'b1;
      return r;
   endfunction

   logic [31:0]    mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [PTR_W:0] count;
   logic           push_p0, pop_p0, drop_p0;
   logic           ev_inv_p0, ev_ovf_p0, ev_unf_p0, zero_p0;
   logic [31:0]    pack_p0;

   // Stage 0: pack and classify the incoming result
   assign in_ready  = (count != FULL_CNT);
   assign out_valid = (count != '0);
   assign out_data  = mem[rd_ptr];
   assign push_p0   = in_valid & in_ready;
   assign pop_p0    = out_valid & out_ready;
   assign drop_p0   = in_valid & ~in_ready;
   assign pack_p0   = pack_word(in_sign, in_exp, in_frac, in_error, in_overflow);
   assign zero_p0   = (in_exp == 8'd0) || (in_exp == 8'd1 && !in_frac[23]) || (in_frac == 24'd0);
   assign ev_inv_p0 = push_p0 & in_error;
   assign ev_ovf_p0 = push_p0 & ~in_error & (in_overflow | (in_exp == 8'hFF));
   assign ev_unf_p0 = push_p0 & ~in_error & ~in_overflow & (in_exp != 8'hFF) & zero_p0
                      & (in_frac != 24'd0);

   // Stage 1: FIFO storage, occupancy and status
   always_ff @(posedge clk) begin
      if (RESET) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else if (push_p0) begin
         mem[wr_ptr] <= pack_p0;
      end
   end

   always_ff @(posedge clk) begin
      if (RESET) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         count          <= '0;
         flag_invalid   <= 1'b0;
         flag_overflow  <= 1'b0;
         flag_underflow <= 1'b0;
         flag_drop      <= 1'b0;
         cnt_invalid    <= '0;
         cnt_overflow   <= '0;
      end else begin
         if (push_p0) wr_ptr <= wr_ptr + 1'b1;
         if (pop_p0)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_p0, pop_p0})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         // a new event in the same cycle as clr_flags wins
         flag_invalid   <= (flag_invalid   & ~clr_flags) | ev_inv_p0;
         flag_overflow  <= (flag_overflow  & ~clr_flags) | ev_ovf_p0;
         flag_underflow <= (flag_underflow & ~clr_flags) | ev_unf_p0;
         flag_drop      <= (flag_drop      & ~clr_flags) | drop_p0;
         cnt_invalid    <= sat_inc(cnt_invalid, ev_inv_p0);
         cnt_overflow   <= sat_inc(cnt_overflow, ev_ovf_p0);
      end
   end

endmodule

// File: tb/tb_fmul_round_pack.sv
// Scoreboard bench for fmul_round_pack: expected words queued on push, compared on pop.
module tb_fmul_round_pack;
   localparam int FIFO_DEPTH = 2;
   localparam int CNT_W      = 4;

   logic             clk = 1'b0;
   logic             RESET, in_valid, in_sign, in_error, in_overflow;
   logic [7:0]       in_exp;
   logic [23:0]      in_frac;
   logic             in_ready, out_valid, out_ready, clr_flags;
   logic [31:0]      out_data;
   logic             flag_invalid, flag_overflow, flag_underflow, flag_drop;
   logic [CNT_W-1:0] cnt_invalid, cnt_overflow;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] exp_q[$];
   logic [31:0] obs_q[$];
   logic [31:0] cur_word, w_exp, w_obs;

   fmul_round_pack #(.FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .RESET(RESET), .in_valid(in_valid), .in_sign(in_sign), .in_exp(in_exp),
      .in_frac(in_frac), .in_error(in_error), .in_overflow(in_overflow), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .clr_flags(clr_flags),
      .flag_invalid(flag_invalid), .flag_overflow(flag_overflow),
      .flag_underflow(flag_underflow), .flag_drop(flag_drop),
      .cnt_invalid(cnt_invalid), .cnt_overflow(cnt_overflow));

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1);
   end

   task automatic tick();
      #1;
      if (in_valid && in_ready) exp_q.push_back(cur_word);
      if (out_valid && out_ready) obs_q.push_back(out_data);
      @(negedge clk);
   endtask

   task automatic drive(input logic s, input logic [7:0] e, input logic [23:0] f,
                        input logic err, input logic ovf, input logic [31:0] expw);
      in_valid = 1'b1; in_sign = s; in_exp = e; in_frac = f;
      in_error = err; in_overflow = ovf; cur_word = expw;
   endtask

   task automatic idle();
      in_valid = 1'b0; in_error = 1'b0; in_overflow = 1'b0;
   endtask

   task automatic drain();
      idle();
      out_ready = 1'b1;
      repeat (2 * FIFO_DEPTH + 2) tick();
   endtask

   task automatic pulse_clr();
      idle(); clr_flags = 1'b1; tick(); clr_flags = 1'b0;
   endtask

   task automatic test_reset();
      RESET = 1'b1; idle(); in_sign = 0; in_exp = 0; in_frac = 0;
      out_ready = 1'b0; clr_flags = 1'b0; cur_word = 0;
      @(negedge clk); tick(); tick();
      RESET = 1'b0; #1;
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
      n_tests++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data: got %08h required 00000000", out_data); end
      n_tests++;
      if ({flag_invalid, flag_overflow, flag_underflow, flag_drop} !== 4'b0000) begin
         n_fail++; $display("FAIL reset_flags: got %b required 0000", {flag_invalid, flag_overflow, flag_underflow, flag_drop});
      end
      n_tests++;
      if (cnt_invalid !== '0 || cnt_overflow !== '0) begin
         n_fail++; $display("FAIL reset_counters: got %0d/%0d required 0/0", cnt_invalid, cnt_overflow);
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_basic();
      out_ready = 1'b1;
      drive(1'b0, 8'h7F, 24'h800000, 1'b0, 1'b0, 32'h3F800000);
      tick(); idle(); #1;
      n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency: got out_valid %b required 1", out_valid); end
      n_tests++; if (out_data !== 32'h3F800000) begin n_fail++; $display("FAIL basic_data: got %08h required 3f800000", out_data); end
      tick(); #1;
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_one_cycle: got out_valid %b required 0", out_valid); end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_pack();
      pulse_clr(); out_ready = 1'b1; exp_q.delete(); obs_q.delete();
      drive(1'b1, 8'h05, 24'h000000, 1'b0, 1'b0, 32'h80000000);
      tick(); #1;
      n_tests++; if (flag_underflow !== 1'b0) begin n_fail++; $display("FAIL pack_zero_no_unf: got %b required 0", flag_underflow); end
      drive(1'b0, 8'h80, 24'h400000, 1'b0, 1'b0, 32'h3F800000); tick();
      drive(1'b0, 8'h01, 24'h400000, 1'b0, 1'b0, 32'h00000000); tick(); #1;
      n_tests++; if (flag_underflow !== 1'b1) begin n_fail++; $display("FAIL pack_underflow: got %b required 1", flag_underflow); end
      drive(1'b1, 8'h00, 24'h000001, 1'b0, 1'b0, 32'h80000000); tick();
      drive(1'b0, 8'hFF, 24'h800000, 1'b0, 1'b0, 32'h7F800000); tick();
      drive(1'b1, 8'h90, 24'h123456, 1'b0, 1'b0, 32'hC7A468AC); tick();
      drive(1'b0, 8'h02, 24'h7FFFFF, 1'b0, 1'b0, 32'h00FFFFFE); tick();
      drain();
      n_tests++;
      if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL pack_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() != 0 && obs_q.size() != 0) begin
         w_exp = exp_q.pop_front(); w_obs = obs_q.pop_front(); n_tests++;
         if (w_obs !== w_exp) begin n_fail++; $display("FAIL pack_word: got %08h required %08h", w_obs, w_exp); end
      end
   endtask

   task automatic test_flags();
      RESET = 1'b1; idle(); tick(); RESET = 1'b0;
      out_ready = 1'b1; exp_q.delete(); obs_q.delete();
      drive(1'b1, 8'h00, 24'h000000, 1'b1, 1'b0, 32'h7FC00000); tick(); idle(); #1;
      n_tests++; if (flag_invalid !== 1'b1) begin n_fail++; $display("FAIL flag_invalid: got %b required 1", flag_invalid); end
      n_tests++; if (cnt_invalid !== 4'd1) begin n_fail++; $display("FAIL cnt_invalid: got %0d required 1", cnt_invalid); end
      drive(1'b1, 8'h10, 24'h800000, 1'b0, 1'b1, 32'hFF800000); tick(); idle(); #1;
      n_tests++; if (flag_overflow !== 1'b1) begin n_fail++; $display("FAIL flag_overflow: got %b required 1", flag_overflow); end
      n_tests++; if (cnt_overflow !== 4'd1) begin n_fail++; $display("FAIL cnt_overflow: got %0d required 1", cnt_overflow); end
      drive(1'b0, 8'h00, 24'h000000, 1'b1, 1'b0, 32'h7FC00000); clr_flags = 1'b1; tick();
      clr_flags = 1'b0; idle(); #1;
      n_tests++; if (flag_invalid !== 1'b1) begin n_fail++; $display("FAIL set_wins_clear: got %b required 1", flag_invalid); end
      pulse_clr(); #1;
      n_tests++;
      if ({flag_invalid, flag_overflow} !== 2'b00) begin
         n_fail++; $display("FAIL clr_flags: got %b required 00", {flag_invalid, flag_overflow});
      end
      n_tests++;
      if (cnt_invalid !== 4'd2 || cnt_overflow !== 4'd1) begin
         n_fail++; $display("FAIL clr_keeps_counters: got %0d/%0d required 2/1", cnt_invalid, cnt_overflow);
      end
      drain();
      n_tests++;
      if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL flags_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() != 0 && obs_q.size() != 0) begin
         w_exp = exp_q.pop_front(); w_obs = obs_q.pop_front(); n_tests++;
         if (w_obs !== w_exp) begin n_fail++; $display("FAIL flags_word: got %08h required %08h", w_obs, w_exp); end
      end
   endtask

   task automatic test_full_drop();
      pulse_clr(); out_ready = 1'b0; exp_q.delete(); obs_q.delete();
      drive(1'b0, 8'h7F, 24'h800000, 1'b0, 1'b0, 32'h3F800000); tick();
      drive(1'b0, 8'h80, 24'h800000, 1'b0, 1'b0, 32'h40000000); tick(); #1;
      n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready: got %b required 0", in_ready); end
      drive(1'b0, 8'h00, 24'h000000, 1'b1, 1'b0, 32'h7FC00000); tick(); idle(); #1;
      n_tests++; if (flag_drop !== 1'b1) begin n_fail++; $display("FAIL flag_drop: got %b required 1", flag_drop); end
      n_tests++;
      if (flag_invalid !== 1'b0 || cnt_invalid !== 4'd2) begin
         n_fail++; $display("FAIL drop_no_event: got flag %b cnt %0d required 0/2", flag_invalid, cnt_invalid);
      end
      tick(); tick(); #1;
      n_tests++; if (out_data !== 32'h3F800000) begin n_fail++; $display("FAIL stall_stable: got %08h required 3f800000", out_data); end
      drain();
      n_tests++;
      if (obs_q.size() !== 2 || exp_q.size() !== 2) begin
         n_fail++; $display("FAIL drain_count: got %0d/%0d required 2/2", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() != 0 && obs_q.size() != 0) begin
         w_exp = exp_q.pop_front(); w_obs = obs_q.pop_front(); n_tests++;
         if (w_obs !== w_exp) begin n_fail++; $display("FAIL drain_order: got %08h required %08h", w_obs, w_exp); end
      end
   endtask

   task automatic test_back_to_back();
      logic        s;
      logic [7:0]  e;
      logic [23:0] f;
      pulse_clr(); out_ready = 1'b1; exp_q.delete(); obs_q.delete();
      for (int i = 0; i < 12; i++) begin
         s = 1'($urandom_range(0, 1));
         e = 8'($urandom_range(1, 254));
         f = 24'h800000 | 24'($urandom_range(0, 24'h7FFFFF));
         drive(s, e, f, 1'b0, 1'b0, {s, e, f[22:0]});
         tick();
         if (i > 0) begin
            n_tests++;
            if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
               n_fail++; $display("FAIL steady_occupancy: got in_ready %b out_valid %b required 1/1", in_ready, out_valid);
            end
         end
      end
      drain();
      n_tests++; if (flag_drop !== 1'b0) begin n_fail++; $display("FAIL steady_no_drop: got %b required 0", flag_drop); end
      n_tests++;
      if (obs_q.size() !== 12 || exp_q.size() !== 12) begin
         n_fail++; $display("FAIL steady_count: got %0d/%0d required 12/12", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() != 0 && obs_q.size() != 0) begin
         w_exp = exp_q.pop_front(); w_obs = obs_q.pop_front(); n_tests++;
         if (w_obs !== w_exp) begin n_fail++; $display("FAIL steady_word: got %08h required %08h", w_obs, w_exp); end
      end
   endtask

   task automatic test_saturate();
      RESET = 1'b1; idle(); tick(); RESET = 1'b0;
      out_ready = 1'b1; exp_q.delete(); obs_q.delete();
      for (int i = 0; i < 20; i++) begin
         drive(1'b0, 8'hFF, 24'h000000, 1'b0, 1'b0, 32'h7F800000);
         tick();
      end
      idle(); #1;
      n_tests++; if (cnt_overflow !== 4'd15) begin n_fail++; $display("FAIL cnt_saturate: got %0d required 15", cnt_overflow); end
      drain();
      n_tests++;
      if (obs_q.size() !== 20 || exp_q.size() !== 20) begin
         n_fail++; $display("FAIL sat_count: got %0d/%0d required 20/20", obs_q.size(), exp_q.size());
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      drive(1'b0, 8'h00, 24'h000000, 1'b1, 1'b0, 32'h7FC00000); tick();
      drive(1'b1, 8'h20, 24'h800000, 1'b0, 1'b1, 32'hFF800000); tick();
      drive(1'b0, 8'h7F, 24'h800000, 1'b0, 1'b0, 32'h3F800000);
      RESET = 1'b1; out_ready = 1'b1; clr_flags = 1'b0; tick();
      RESET = 1'b0; idle(); #1;
      n_tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++; $display("FAIL midreset_fifo: got out_valid %b in_ready %b required 0/1", out_valid, in_ready);
      end
      n_tests++;
      if ({flag_invalid, flag_overflow, flag_underflow, flag_drop} !== 4'b0000 || cnt_invalid !== '0 || cnt_overflow !== '0) begin
         n_fail++; $display("FAIL midreset_status: got flags %b cnts %0d/%0d required 0000 0/0",
                            {flag_invalid, flag_overflow, flag_underflow, flag_drop}, cnt_invalid, cnt_overflow);
      end
      exp_q.delete(); obs_q.delete();
      drive(1'b0, 8'h7F, 24'h800000, 1'b0, 1'b0, 32'h3F800000); tick(); idle(); #1;
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== 32'h3F800000) begin
         n_fail++; $display("FAIL post_reset_push: got %b %08h required 1 3f800000", out_valid, out_data);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_pack();
      test_flags();
      test_full_drop();
      test_back_to_back();
      test_saturate();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/fmul_round_pack.md
FMUL_ROUND_PACK -- requirements
Module: fmul_round_pack

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, output buffer entries (power of two, 2..8).
REQ-002 SHALL have parameter CNT_W, default 16, width of each event counter.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port RESET  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  in  1  FMUL final-stage result present this cycle.
REQ-006 SHALL have ports in_sign  in  1, in_exp  in  8, in_frac  in  24 (bit 23 = integer bit), in_error  in  1, in_overflow  in  1  FMUL result fields.
REQ-007 SHALL have port in_ready  out  1  buffer can accept a result this cycle.
REQ-008 SHALL have port out_valid  out  1  out_data holds a packed result.
REQ-009 SHALL have port out_data  out  32  IEEE-754 single word {sign, exp[7:0], frac[22:0]}.
REQ-010 SHALL have port out_ready  in  1  consumer takes out_data when out_valid high.
REQ-011 SHALL have port clr_flags  in  1  clears sticky flags.
REQ-012 SHALL have ports flag_invalid, flag_overflow, flag_underflow, flag_drop  out  1 each  sticky status.
REQ-013 SHALL have ports cnt_invalid, cnt_overflow  out  CNT_W each  event counts.

Function
REQ-014 Push = in_valid & in_ready; pop = out_valid & out_ready.
REQ-015 in_ready SHALL equal !full, derived from registered occupancy only (no combinational dependence on out_ready).
REQ-016 Pack priority: in_error -> 0x7FC00000 (sign ignored); else in_overflow or in_exp==255 -> {in_sign, 0xFF, 0}; else zero/underflow rule; else normal.
REQ-017 Normal, in_frac[23]=1: word = {in_sign, in_exp, in_frac[22:0]}.
REQ-018 Normalize, in_frac[23]=0, in_exp>=2: single left shift, word = {in_sign, in_exp-1, in_frac[21:0], 1'b0}.
REQ-019 Zero/underflow: in_exp==0, or in_frac[23]=0 with in_exp==1, or in_frac==0 -> {in_sign, 31'b0}; underflow event only when in_frac!=0.
REQ-020 Packed word written to FIFO on push; out_valid rises the cycle after push into empty FIFO (latency 1).
REQ-021 FIFO strict in-order; out_data = head entry, stable while out_valid & !out_ready.
REQ-022 Simultaneous push and pop: occupancy unchanged, both take effect; pointers wrap modulo FIFO_DEPTH.
REQ-023 in_valid & !in_ready: result discarded, flag_drop set; FIFO contents unchanged.
REQ-024 Events (invalid, overflow, underflow) counted/flagged only on push, never on drop.
REQ-025 Counters saturate at 2^CNT_W-1; no wrap.
REQ-026 Flags set on event; clr_flags clears; same-cycle set and clear -> flag ends 1. clr_flags does not clear counters.
REQ-027 FIFO empty: out_valid=0, out_data holds last value (don't-care for checking).

Reset
REQ-028 RESET high at edge: occupancy 0, pointers 0, out_valid 0, in_ready 1, all flags 0, counters 0, out_data 0.
REQ-029 RESET dominates all same-cycle push/pop/clr_flags; in-flight entries discarded.

Verification
REQ-030 Push sign0 exp 0x7F frac 0x800000, out_ready=1 -> next cycle out_valid=1, out_data=0x3F800000, one cycle only.
REQ-031 Push exp 0x80 frac 0x400000 -> out_data 0x3F800000; push exp 0x01 frac 0x400000 -> 0x00000000, flag_underflow=1.
REQ-032 Push in_error=1 sign1 -> 0x7FC00000, flag_invalid=1, cnt_invalid=1; push in_overflow=1 sign1 -> 0xFF800000, cnt_overflow=1.
REQ-033 out_ready=0, FIFO_DEPTH=2, three back-to-back pushes -> in_ready=0 after second, third dropped, flag_drop=1; then out_ready=1 drains two entries in order.
REQ-034 Steady push+pop every cycle for 10 cycles -> occupancy constant, no drops, outputs in input order.
REQ-035 RESET asserted with 2 entries and flags set -> next cycle out_valid=0, in_ready=1, flags and counters 0.
